ifu: RTL



---
 rtl/brq_ifu_pkg.sv | 21 ++
 rtl/ifu_skid_buf.sv | 36 +++
 rtl/ifu.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/brq_ifu_pkg.sv
// Shared types and constants for the Buraq-mini instruction fetch unit.
package brq_ifu_pkg;

    // addi x0, x0, 0 -- the canonical RISC-V bubble
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        SEQ    = 2'b00,
        BRANCH = 2'b01,
        JAL    = 2'b10,
        JALR   = 2'b11
    } next_pc_sel_e;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        REQ_BLOCKED
    } ifu_state_e;

endpackage

// File: rtl/ifu_skid_buf.sv
// One-entry {inst, pc} holding register that catches a response arriving
// while decode is stalled.
module ifu_skid_buf #(
    parameter int unsigned DataWidth = 32
) (
    input  logic                 brq_clk,
    input  logic                 brq_rst,
    input  logic                 load,
    input  logic                 drain,
    input  logic                 clear,
    input  logic [DataWidth-1:0] in_inst,
    input  logic [DataWidth-1:0] in_pc,
    output logic                 valid,
    output logic [DataWidth-1:0] out_inst,
    output logic [DataWidth-1:0] out_pc
);

    // Occupancy: load wins over drain so a simultaneous drain+refill stays full.
    always_ff @(posedge brq_clk) begin
        if (brq_rst || clear) valid <= 1'b0;
        else if (load)        valid <= 1'b1;
        else if (drain)       valid <= 1'b0;
    end

    // Payload capture; contents are don't-care while empty.
    always_ff @(posedge brq_clk) begin
        if (brq_rst) begin
            out_inst <= '0;
            out_pc   <= '0;
        end else if (load) begin
            out_inst <= in_inst;
            out_pc   <= in_pc;
        end
    end

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: owns the fetch PC, drives the imem req/gnt/rvalid
// handshake (one outstanding) and presents a registered inst/pc pair to decode.
module ifu
    import brq_ifu_pkg::*;
#(
    parameter int unsigned          DataWidth = 32,
    parameter logic [DataWidth-1:0] RESET_PC  = '0
) (
    input  logic                 brq_clk,
    input  logic                 brq_rst,
    output logic                 imem_req,
    output logic [DataWidth-1:0] imem_addr,
    input  logic                 imem_gnt,
    input  logic                 imem_rvalid,
    input  logic [DataWidth-1:0] imem_rdata,
    input  logic                 ifu_hold,
    input  logic                 idu_flush,
    input  logic [1:0]           idu_next_pc_sel,
    input  logic                 idu_branch,
    input  logic [DataWidth-1:0] idu_branch_addr,
    input  logic [DataWidth-1:0] idu_jal_addr,
    input  logic [DataWidth-1:0] idu_jalr_addr,
    output logic [DataWidth-1:0] ifu_fetch_inst,
    output logic [DataWidth-1:0] ifu_pc,
    output logic                 ifu_stall
);

    localparam logic [DataWidth-1:0] NOP_W = DataWidth'(NOP);

    ifu_state_e           state, state_d;
    logic [DataWidth-1:0] fetch_pc, inflight_pc, redir_pc, target;
    logic                 discard, redir_pend;
    logic                 buf_valid;
    logic [DataWidth-1:0] buf_inst, buf_pc;
    logic                 rsp_use, out_load, consume, buf_load, buf_drain, fire;

    // A response is usable unless it belongs to a squashed fetch.
    assign rsp_use   = imem_rvalid && !discard && !idu_flush;
    assign out_load  = !idu_flush && !ifu_hold;
    // Straight-to-output path; also the condition that allows back-to-back issue.
    assign consume   = rsp_use && out_load && !buf_valid;
    assign buf_load  = rsp_use && !consume;
    assign buf_drain = out_load && buf_valid;
    assign fire      = imem_req && imem_gnt;
    assign imem_addr = {fetch_pc[DataWidth-1:2], 2'b00};

    // Redirect target; SEQ or a not-taken branch leaves the PC where it is.
    always_comb begin
        target = fetch_pc;
        case (next_pc_sel_e'(idu_next_pc_sel))
            BRANCH:  if (idu_branch) target = idu_branch_addr;
            JAL:     target = idu_jal_addr;
            JALR:    target = idu_jalr_addr;
            default: ;
        endcase
        target[1:0] = 2'b00;
    end

    // Next-state and request generation.
    always_comb begin
        state_d  = state;
        imem_req = 1'b0;
        case (state)
            IDLE: state_d = REQ;
            REQ: begin
                imem_req = 1'b1;
                if (imem_gnt) state_d = WAIT;
            end
            WAIT: begin
                if (imem_rvalid) begin
                    if (consume) begin
                        imem_req = 1'b1;
                        state_d  = imem_gnt ? WAIT : REQ;
                    end else begin
                        state_d = REQ_BLOCKED;
                    end
                end
            end
            REQ_BLOCKED: begin
                imem_req = !buf_valid;
                if (!buf_valid && imem_gnt) state_d = WAIT;
            end
            default: state_d = IDLE;
        endcase
    end

    // Fetch PC, in-flight PC, squash tracking and deferred redirect.
    always_ff @(posedge brq_clk) begin
        if (brq_rst) begin
            state       <= IDLE;
            fetch_pc    <= RESET_PC;
            inflight_pc <= '0;
            redir_pc    <= '0;
            redir_pend  <= 1'b0;
            discard     <= 1'b0;
        end else begin
            state <= state_d;
            if (fire) inflight_pc <= imem_addr;
            // An ungranted request must keep its address, so park the target.
            if (idu_flush && imem_req && !imem_gnt) begin
                redir_pend <= 1'b1;
                redir_pc   <= target;
            end else if (idu_flush) begin
                fetch_pc   <= target;
                redir_pend <= 1'b0;
            end else if (fire) begin
                fetch_pc   <= redir_pend ? redir_pc : fetch_pc + DataWidth'(4);
                redir_pend <= 1'b0;
            end
            if (imem_rvalid) discard <= 1'b0;
            // Squash whatever is in flight or about to be; a same-cycle rvalid
            // has already been dropped via rsp_use.
            if (idu_flush && ((state == WAIT && !imem_rvalid) || imem_req)) discard <= 1'b1;
        end
    end

    ifu_skid_buf #(.DataWidth(DataWidth)) u_skid (
        .brq_clk  (brq_clk),
        .brq_rst  (brq_rst),
        .load     (buf_load),
        .drain    (buf_drain),
        .clear    (idu_flush),
        .in_inst  (imem_rdata),
        .in_pc    (inflight_pc),
        .valid    (buf_valid),
        .out_inst (buf_inst),
        .out_pc   (buf_pc)
    );

    // Decode-facing register: flush beats hold, hold freezes, else buffer/response/bubble.
    always_ff @(posedge brq_clk) begin
        if (brq_rst) begin
            ifu_fetch_inst <= NOP_W;
            ifu_pc         <= '0;
            ifu_stall      <= 1'b1;
        end else if (idu_flush) begin
            ifu_fetch_inst <= NOP_W;
            ifu_stall      <= 1'b1;
        end else if (!ifu_hold) begin
            if (buf_valid) begin
                ifu_fetch_inst <= buf_inst;
                ifu_pc         <= buf_pc;
                ifu_stall      <= 1'b0;
            end else if (rsp_use) begin
                ifu_fetch_inst <= imem_rdata;
                ifu_pc         <= inflight_pc;
                ifu_stall      <= 1'b0;
            end else begin
                ifu_fetch_inst <= NOP_W;
                ifu_stall      <= 1'b1;
            end
        end
    end

endmodule
